logic_gate_pipe: RTL and testbench

//   Parametrised, registered N-input, W-bit bitwise gate unit. Generalises the 2-input AND gate:

---
 rtl/logic_gate_pipe_pkg.sv | 29 ++
 rtl/logic_gate_pipe_fold.sv | 56 +++++
 rtl/logic_gate_pipe.sv | 115 +++++++++++
 tb/tb_logic_gate_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : gate_pkg
// Purpose : Shared definitions for the pipelined gate unit. Provides the op
//           select encodings, the op select width and the output register
//           state type.
// Revision: 1.0 - initial release
// ============================================================================
package gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

  // Output register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : gate_pkg
`default_nettype wire

// File: rtl/logic_gate_pipe_fold.sv
`default_nettype none
// ============================================================================
// Module  : gate_fold
// Purpose : Combinational N-input bitwise gate. Folds the selected op across
//           all NUM_IN operands; NOT/BUF use operand 0 only.
// Ports   : in_op   [OP_W-1:0]         op select
//           in_data [NUM_IN*WIDTH-1:0] packed operands, k at [k*WIDTH +: WIDTH]
//           result  [WIDTH-1:0]        gate output
// Revision: 1.0 - initial release
// ============================================================================
module gate_fold
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [OP_W-1:0]         in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] and_f;
  logic [WIDTH-1:0] or_f;
  logic [WIDTH-1:0] xor_f;

  assign op0 = in_data[WIDTH-1:0];

  always_comb begin
    and_f = op0;
    or_f  = op0;
    xor_f = op0;
    for (int k = 1; k < NUM_IN; k++) begin
      and_f = and_f & in_data[k*WIDTH +: WIDTH];
      or_f  = or_f  | in_data[k*WIDTH +: WIDTH];
      xor_f = xor_f ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = op0;
    case (in_op)
      OP_AND:  result = and_f;
      OP_OR:   result = or_f;
      OP_XOR:  result = xor_f;
      OP_NAND: result = ~and_f;
      OP_NOR:  result = ~or_f;
      OP_XNOR: result = ~xor_f;
      OP_NOT:  result = ~op0;
      OP_BUF:  result = op0;
      default: result = op0;
    endcase
  end

endmodule : gate_fold
`default_nettype wire

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module  : logic_gate_pipe
// Purpose : Registered N-input, W-bit bitwise gate unit with valid/ready
//           handshake on both sides, one output register stage, zero/ones
//           flags and a saturating accepted-transaction counter.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready/in_op/in_data   - operand side
//           out_valid/out_ready/out_data      - result side
//           out_zero/out_ones                 - result flags, registered
//           clr_cnt/acc_cnt                   - transaction counter
// Revision: 1.0 - initial release
// ============================================================================
module logic_gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_ones,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        acc_cnt
);

  generate
    if (NUM_IN < 2 || WIDTH < 1) begin : g_param_check
      $fatal(1, "logic_gate_pipe: NUM_IN must be >= 2 and WIDTH >= 1");
    end
  endgenerate

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] fold_result;
  logic             accept;
  logic             xfer;

  gate_fold #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_fold (
    .in_op   (in_op),
    .in_data (in_data),
    .result  (fold_result)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  // Result register only loads on accept, so don't-care operands presented
  // with in_valid low never reach it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = fold_result;
      zero_d  = (fold_result == '0);
      ones_d  = &fold_result;
    end else if (xfer) begin
      state_d = ST_EMPTY;
    end
  end

  // Clear wins over a simultaneous accept; count sticks at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data = data_q;
  assign out_zero = zero_q;
  assign out_ones = ones_q;
  assign acc_cnt  = cnt_q;

endmodule : logic_gate_pipe
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_gate_pipe
// Purpose : Directed self-checking bench. Instance a is WIDTH=1/NUM_IN=2,
//           instance b is WIDTH=8/NUM_IN=3/CNT_W=3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance a: WIDTH=1, NUM_IN=2, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0]  a_in_op;
  logic [1:0]  a_in_data;
  logic [0:0]  a_out_data;
  logic        a_out_zero, a_out_ones, a_clr_cnt;
  logic [15:0] a_acc_cnt;

  // Instance b: WIDTH=8, NUM_IN=3, CNT_W=3
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_in_op;
  logic [23:0] b_in_data;
  logic [7:0]  b_out_data;
  logic        b_out_zero, b_out_ones, b_clr_cnt;
  logic [2:0]  b_acc_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_zero(a_out_zero), .out_ones(a_out_ones),
    .clr_cnt(a_clr_cnt), .acc_cnt(a_acc_cnt)
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_zero(b_out_zero), .out_ones(b_out_ones),
    .clr_cnt(b_clr_cnt), .acc_cnt(b_acc_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total_cnt++;
    if ({a_out_valid, a_out_data, a_out_zero, a_out_ones} !== 4'b0000 || a_acc_cnt !== 16'd0)
      $display("FAIL reset_a: valid/data/zero/ones=%b acc=%0d, required 0000 acc=0",
               {a_out_valid, a_out_data, a_out_zero, a_out_ones}, a_acc_cnt);
    else pass_cnt++;
    total_cnt++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_zero !== 1'b0 ||
        b_out_ones !== 1'b0 || b_acc_cnt !== 3'd0)
      $display("FAIL reset_b: valid=%b data=%h zero=%b ones=%b acc=%0d, required all 0",
               b_out_valid, b_out_data, b_out_zero, b_out_ones, b_acc_cnt);
    else pass_cnt++;
    total_cnt++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      $display("FAIL reset_in_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  // AND truth table on the 1-bit, 2-input instance, one vector per 10 cycles.
  task automatic test_and_w1();
    logic [1:0] xy [4];
    logic [0:0] exp_res [4];
    xy[0] = 2'b00; xy[1] = 2'b01; xy[2] = 2'b10; xy[3] = 2'b11;
    exp_res[0] = 1'b0; exp_res[1] = 1'b0; exp_res[2] = 1'b0; exp_res[3] = 1'b1;
    a_out_ready = 1'b1;
    a_in_op     = 3'd0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = {xy[i][0], xy[i][1]};  // operand 0 = x, operand 1 = y
      step();
      a_in_valid = 1'b0;
      a_in_data  = 2'b00;
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_res[i])
        $display("FAIL and_w1[%0d]: valid=%b data=%b, required valid=1 data=%b",
                 i, a_out_valid, a_out_data, exp_res[i]);
      else pass_cnt++;
      repeat (9) step();
    end
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_acc_cnt !== 16'd4)
      $display("FAIL and_w1_end: valid=%b acc=%0d, required valid=0 acc=4", a_out_valid, a_acc_cnt);
    else pass_cnt++;
  endtask

  // Every op on fixed operands, issued back to back.
  task automatic test_ops_w8();
    logic [2:0]  ops  [8];
    logic [23:0] data [8];
    logic [7:0]  exp_d [8];
    logic        exp_z [8];
    logic        exp_o [8];
    ops[0] = 3'd2; data[0] = {8'h0F, 8'h3C, 8'hF0}; exp_d[0] = 8'hC3; exp_z[0] = 0; exp_o[0] = 0;
    ops[1] = 3'd4; data[1] = {8'h0F, 8'h3C, 8'hF0}; exp_d[1] = 8'h00; exp_z[1] = 1; exp_o[1] = 0;
    ops[2] = 3'd3; data[2] = {8'hFF, 8'hFF, 8'hFF}; exp_d[2] = 8'h00; exp_z[2] = 1; exp_o[2] = 0;
    ops[3] = 3'd6; data[3] = {8'h34, 8'h12, 8'h00}; exp_d[3] = 8'hFF; exp_z[3] = 0; exp_o[3] = 1;
    ops[4] = 3'd5; data[4] = {8'h0F, 8'h3C, 8'hF0}; exp_d[4] = 8'h3C; exp_z[4] = 0; exp_o[4] = 0;
    ops[5] = 3'd1; data[5] = {8'h0F, 8'h3C, 8'hF0}; exp_d[5] = 8'hFF; exp_z[5] = 0; exp_o[5] = 1;
    ops[6] = 3'd0; data[6] = {8'hF7, 8'h3C, 8'hF4}; exp_d[6] = 8'h34; exp_z[6] = 0; exp_o[6] = 0;
    ops[7] = 3'd7; data[7] = {8'hFF, 8'h00, 8'h5A}; exp_d[7] = 8'h5A; exp_z[7] = 0; exp_o[7] = 0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_op    = ops[i];
      b_in_data  = data[i];
      step();
      total_cnt++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i] ||
          b_out_zero !== exp_z[i] || b_out_ones !== exp_o[i])
        $display("FAIL op%0d_w8: valid=%b data=%h zero=%b ones=%b, required 1 %h %b %b",
                 ops[i], b_out_valid, b_out_data, b_out_zero, b_out_ones,
                 exp_d[i], exp_z[i], exp_o[i]);
      else pass_cnt++;
    end
    b_in_valid = 1'b0;
    step();
    total_cnt++;
    if (b_out_valid !== 1'b0)
      $display("FAIL ops_drain: valid=%b, required 0", b_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    b_clr_cnt = 1'b1;
    step();
    b_clr_cnt   = 1'b0;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_op     = 3'd7;
    b_in_data   = {8'h00, 8'h00, 8'hA5};
    step();
    b_in_data = {8'h00, 8'h00, vals[0]};
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_out_data !== 8'hA5)
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b data=%h, required 1 0 a5",
                 i, b_out_valid, b_in_ready, b_out_data);
      else pass_cnt++;
      step();
    end
    b_out_ready = 1'b1;
    #1;
    total_cnt++;
    if (b_in_ready !== 1'b1 || b_acc_cnt !== 3'd1)
      $display("FAIL bp_release: in_ready=%b acc=%0d, required 1 1", b_in_ready, b_acc_cnt);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      b_in_data = {8'h00, 8'h00, vals[i]};
      step();
      total_cnt++;
      if (b_out_valid !== 1'b1 || b_out_data !== vals[i])
        $display("FAIL bp_b2b[%0d]: valid=%b data=%h, required 1 %h",
                 i, b_out_valid, b_out_data, vals[i]);
      else pass_cnt++;
    end
    b_in_valid = 1'b0;
    step();
    total_cnt++;
    if (b_out_valid !== 1'b0 || b_acc_cnt !== 3'd4)
      $display("FAIL bp_end: valid=%b acc=%0d, required 0 4", b_out_valid, b_acc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_counter();
    logic [2:0] exp_c;
    b_clr_cnt = 1'b1;
    step();
    b_clr_cnt = 1'b0;
    total_cnt++;
    if (b_acc_cnt !== 3'd0)
      $display("FAIL cnt_clear: acc=%0d, required 0", b_acc_cnt);
    else pass_cnt++;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_op     = 3'd0;
    b_in_data   = 24'h010203;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_c = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      total_cnt++;
      if (b_acc_cnt !== exp_c)
        $display("FAIL cnt_sat[%0d]: acc=%0d, required %0d", i, b_acc_cnt, exp_c);
      else pass_cnt++;
    end
    b_clr_cnt = 1'b1;
    step();
    b_clr_cnt  = 1'b0;
    b_in_valid = 1'b0;
    total_cnt++;
    if (b_acc_cnt !== 3'd0 || b_out_valid !== 1'b1)
      $display("FAIL cnt_clr_accept: acc=%0d valid=%b, required 0 1", b_acc_cnt, b_out_valid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_op     = 3'd7;
    b_in_data   = {8'h00, 8'h00, 8'h77};
    step();
    total_cnt++;
    if (b_out_valid !== 1'b1 || b_out_data !== 8'h77 || b_acc_cnt !== 3'd1)
      $display("FAIL rstmid_pre: valid=%b data=%h acc=%0d, required 1 77 1",
               b_out_valid, b_out_data, b_acc_cnt);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_acc_cnt !== 3'd0)
      $display("FAIL rstmid_async: valid=%b data=%h acc=%0d, required 0 00 0",
               b_out_valid, b_out_data, b_acc_cnt);
    else pass_cnt++;
    b_out_ready = 1'b1;
    step();
    total_cnt++;
    if (b_out_valid !== 1'b0 || b_acc_cnt !== 3'd0)
      $display("FAIL rstmid_held: valid=%b acc=%0d, required 0 0", b_out_valid, b_acc_cnt);
    else pass_cnt++;
    b_in_valid = 1'b0;
    rst = 1'b0;
    step();
    total_cnt++;
    if (b_out_valid !== 1'b0 || b_acc_cnt !== 3'd0)
      $display("FAIL rstmid_after: valid=%b acc=%0d, required 0 0", b_out_valid, b_acc_cnt);
    else pass_cnt++;
  endtask

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_op = 3'd0; a_in_data = '0; a_clr_cnt = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_op = 3'd0; b_in_data = '0; b_clr_cnt = 1'b0;
    test_reset();
    test_and_w1();
    test_ops_w8();
    test_backpressure();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_logic_gate_pipe
`default_nettype wire
